// File: rtl/hs4_bd_tx.sv
// hs4_bd_tx: clocked 4-phase (return-to-zero) bundled-data transmitter.
// Takes words from synchronous logic over valid/ready and sends each one to an
// asynchronous C-element stage as req up -> ack up -> req down -> ack down.
// Optional build macro: HS4_TIMEOUT_EN adds a per-edge ack timeout and a
// sticky ERR state; without it the FSM waits on ack indefinitely.
//
// Handshake on the synchronous side: a word moves on a rising edge of
// wb_clk_i where in_valid && in_ready are both 1. in_ready depends only on
// registered state, never on in_valid, and in_data is ignored otherwise.
module hs4_bd_tx #(
    parameter int DATA_W         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic [7:0]        xfer_cnt_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

`ifdef HS4_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Last wait-count value before the timeout fires (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   done_q, done_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;

    // Synchronize the asynchronous ack into the wb_clk_i domain.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

`ifdef HS4_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
`endif

    // Next-state and output logic for the 4-phase sequencer.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef HS4_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Data and req move on the same edge so data is valid no
                    // later than the req rise seen by the async stage.
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
`ifdef HS4_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
`ifdef HS4_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
`endif
            end
`ifdef HS4_TIMEOUT_EN
            ERR: begin
                // Sticky until reset: ack and in_valid are both ignored.
                req_d = 1'b0;
            end
`endif
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef HS4_TIMEOUT_EN
    // Wait counter restarts on every state entry and runs while waiting on ack.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q == REQ_HI || state_q == REQ_LO) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // State, request, data, completion pulse and transfer count registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // A lingering ack from a previous or spurious cycle blocks new words.
    assign in_ready   = (state_q == IDLE) && !ack_s;
    assign req_o      = req_q;
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign xfer_cnt_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_hs4_bd_tx.sv
// Bench for hs4_bd_tx: table of single-word transfers with hand-computed
// req-fall / done timing, plus hand-written corner sequences.
module tb_hs4_bd_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       req_o;
  logic [3:0] data_o;
  logic       ack_i;
  logic       done_o;
  logic [7:0] xfer_cnt_o;
  logic       err_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // ack responder: ack_i copies req_o delayed by ack_dly negedges
  logic [15:0] req_hist = '0;
  int          ack_dly  = 3;
  bit          resp_en  = 1'b1;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] word;
    int         dly;
    int         fall_at;   // negedge index (after accept) where req_o is first 0
    int         done_at;   // negedge index where done_o is 1
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  hs4_bd_tx #(
    .DATA_W(4),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .done_o    (done_o),
    .xfer_cnt_o(xfer_cnt_o),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ack responder process
  initial begin
    forever begin
      @(negedge clk);
      req_hist = {req_hist[14:0], req_o};
      if (resp_en) ack_i = req_hist[ack_dly-1];
    end
  end

  // data stability and done pulse width monitor
  initial begin
    logic       p_req, p_ack, p_done, p_rst;
    logic [3:0] p_data;
    p_req = 0; p_ack = 0; p_done = 0; p_rst = 1; p_data = 0;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst) begin
        if (p_req || p_ack) check("data_stable", 32'(data_o), 32'(p_data));
        if (p_done) check("done_width", 32'(done_o), 32'd0);
      end
      p_req = req_o; p_ack = ack_i; p_done = done_o; p_rst = rst; p_data = data_o;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // one word, checked against hand-computed req-fall and done negedges
  task automatic send_vec(input logic [3:0] w, input int d, input int fall_at,
                          input int done_at, input logic [7:0] exp_cnt);
    bit got;
    repeat (8) @(negedge clk);
    ack_dly  = d;
    in_valid = 1'b1;
    in_data  = w;
    got      = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 32'(got), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'(($urandom_range(0, 15)));
    check("data_after_accept", 32'(data_o), 32'(w));
    check("req_after_accept", 32'(req_o), 32'd1);
    check("state_req_hi", 32'(state_o), 32'd1);
    for (int k = 1; k <= done_at; k++) begin
      @(negedge clk);
      if (k == fall_at - 1) check("req_still_high", 32'(req_o), 32'd1);
      if (k == fall_at)     check("req_fall", 32'(req_o), 32'd0);
      if (k == done_at - 1) check("done_not_early", 32'(done_o), 32'd0);
      if (k == done_at) begin
        check("done_pulse", 32'(done_o), 32'd1);
        check("xfer_cnt", 32'(xfer_cnt_o), 32'(exp_cnt));
        check("ready_back", 32'(in_ready), 32'd1);
        check("state_idle", 32'(state_o), 32'd0);
      end
    end
    @(negedge clk);
    check("done_cleared", 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones;
    int nwords;
    logic p_r;

    vecs[0] = '{word: 4'hA, dly: 3, fall_at: 5, done_at: 10, exp_cnt: 8'd1};
    vecs[1] = '{word: 4'h5, dly: 1, fall_at: 3, done_at: 6,  exp_cnt: 8'd2};
    vecs[2] = '{word: 4'hF, dly: 2, fall_at: 4, done_at: 8,  exp_cnt: 8'd3};
    vecs[3] = '{word: 4'h0, dly: 5, fall_at: 7, done_at: 14, exp_cnt: 8'd4};
    vecs[4] = '{word: 4'h3, dly: 3, fall_at: 5, done_at: 10, exp_cnt: 8'd5};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; ack_i = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_cnt", 32'(xfer_cnt_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // table-driven single words
    for (int i = 0; i < 5; i++)
      send_vec(vecs[i].word, vecs[i].dly, vecs[i].fall_at, vecs[i].done_at, vecs[i].exp_cnt);

    // back-to-back words with in_valid held high
    ack_dly = 1;
    repeat (8) @(negedge clk);
    exp_q = {4'h1, 4'h2, 4'h3};
    in_data = 4'h1; in_valid = 1'b1; nwords = 1; dones = 0; p_r = req_o;
    for (int t = 0; t < 200 && dones < 3; t++) begin
      @(negedge clk);
      if (req_o && !p_r) begin
        if (exp_q.size() > 0) check("b2b_data", 32'(data_o), 32'(exp_q.pop_front()));
        else check("b2b_extra_word", 32'd1, 32'd0 + 32'(exp_q.size()));
        if (nwords < 3) begin
          nwords++;
          in_data = 4'(nwords);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (done_o) dones++;
      p_r = req_o;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_dones", 32'(dones), 32'd3);
    check("b2b_cnt", 32'(xfer_cnt_o), 32'd8);

    // reset asserted while in REQ_HI with ack low
    resp_en = 1'b0; ack_i = 1'b0;
    repeat (8) @(negedge clk);
    in_valid = 1'b1; in_data = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_req_high", 32'(req_o), 32'd1);
    check("mid_state", 32'(state_o), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req_async", 32'(req_o), 32'd0);
    check("mid_rst_cnt", 32'(xfer_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_state", 32'(state_o), 32'd0);
    check("mid_rel_req", 32'(req_o), 32'd0);
    check("mid_rel_ready", 32'(in_ready), 32'd1);
    check("mid_rel_done", 32'(done_o), 32'd0);

    // ack high across reset release
    ack_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ackhi_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 4'h9;
    repeat (4) @(negedge clk);
    check("ackhi_req", 32'(req_o), 32'd0);
    check("ackhi_state", 32'(state_o), 32'd0);
    in_valid = 1'b0;
    ack_i = 1'b0;
    @(negedge clk);
    check("ackhi_ready_n1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ackhi_ready_n2", 32'(in_ready), 32'd1);
    check("ackhi_cnt", 32'(xfer_cnt_o), 32'd0);
    resp_en = 1'b1;

    // counter wrap: 256 transfers from zero
    for (int i = 0; i < 256; i++)
      send_vec(4'(i), 1, 3, 6, 8'(i + 1));
    check("wrap_cnt_zero", 32'(xfer_cnt_o), 32'd0);

`ifdef HS4_TIMEOUT_EN
    // ack stuck low after accept: timeout after 16 cycles in REQ_HI
    resp_en = 1'b0; ack_i = 1'b0;
    do_reset();
    in_valid = 1'b1; in_data = 4'hC;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        check("tmo_req_before", 32'(req_o), 32'd1);
        check("tmo_err_before", 32'(err_o), 32'd0);
      end
      if (k == 16) begin
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_req", 32'(req_o), 32'd0);
        check("tmo_state", 32'(state_o), 32'd3);
      end
    end
    ack_i = 1'b1; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    ack_i = 1'b0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("err_sticky", 32'(err_o), 32'd1);
    check("err_ready", 32'(in_ready), 32'd0);
    check("err_req", 32'(req_o), 32'd0);
    check("err_cnt", 32'(xfer_cnt_o), 32'd0);
    do_reset();
    check("err_cleared", 32'(err_o), 32'd0);
    check("err_rst_state", 32'(state_o), 32'd0);
    resp_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
